card_deal_scheduler: RTL and testbench
======================================

CARD_DEAL_SCHEDULER -- requirements
Module: card_deal_scheduler

Interface
REQ-001 Parameter: DECK_SIZE, 52, number of card slots in the card memory.
REQ-002 Parameter: ADDR_W, 6, card memory address width; SHALL satisfy 2**ADDR_W >= DECK_SIZE.
REQ-003 Port: clock  in  1  single system clock, all state on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: player_req  in  1  player card request, level, held until player_grant.
REQ-006 Port: dealer_req  in  1  dealer card request, level, held until dealer_grant.
REQ-007 Port: shuffle  in  1  single-cycle pulse, restart deck at slot 0.
REQ-008 Port: mem_data  in  4  card value returned by card memory, valid 1 cycle after mem_rd.
REQ-009 Port: mem_addr  out  ADDR_W  card memory read address.
REQ-010 Port: mem_rd  out  1  card memory read strobe.
REQ-011 Port: card_out  out  4  delivered card value, 1..13.
REQ-012 Port: player_grant  out  1  one-cycle pulse, card_out belongs to player.
REQ-013 Port: dealer_grant  out  1  one-cycle pulse, card_out belongs to dealer.
REQ-014 Port: cards_left  out  ADDR_W  DECK_SIZE minus slots consumed.
REQ-015 Port: deck_empty  out  1  high when cards_left == 0.
REQ-016 Port: bad_card  out  1  sticky flag, invalid memory value seen.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, DELIVER; exactly one active.
REQ-018 IDLE: if (player_req or dealer_req) and not deck_empty -> arbitrate, latch owner, go FETCH; else stay.
REQ-019 Arbitration SHALL be round-robin: single request wins; both requesting -> grant side not served last.
REQ-020 FETCH: mem_rd = 1 for exactly one cycle, mem_addr = deck_ptr; go WAIT.
REQ-021 WAIT: sample mem_data; deck_ptr and slots consumed increment by 1 regardless of value.
REQ-022 WAIT, mem_data in 1..13: card_out <= mem_data, go DELIVER.
REQ-023 WAIT, mem_data 0 or 14..15: bad_card <= 1, value discarded; if deck not now empty go FETCH for same owner, else go IDLE with no grant.
REQ-024 DELIVER: owner's grant pulses for one cycle, other grant 0, update last-served, go IDLE.
REQ-025 Latency, valid card: request sampled in IDLE cycle N -> grant in cycle N+3; each invalid slot adds 2 cycles.
REQ-026 Request deassertion after IDLE acceptance SHALL NOT abort; card still delivered to latched owner.
REQ-027 player_grant and dealer_grant SHALL never be high together; card_out holds last value outside DELIVER.
REQ-028 mem_addr SHALL hold deck_ptr at all times; mem_rd high only in FETCH.
REQ-029 deck_ptr SHALL saturate at DECK_SIZE, never wrap; at DECK_SIZE deck_empty = 1, requests ignored in IDLE.
REQ-030 shuffle in IDLE: deck_ptr <= 0, cards_left <= DECK_SIZE, deck_empty <= 0 next cycle; no fetch begins that cycle.
REQ-031 shuffle outside IDLE: latched pending; applied on first IDLE cycle, taking priority over arbitration that cycle.
REQ-032 bad_card SHALL clear only on reset, not on shuffle.

Reset
REQ-033 reset low SHALL asynchronously force: state IDLE, deck_ptr 0, cards_left DECK_SIZE, deck_empty 0, mem_rd 0, mem_addr 0, card_out 0, both grants 0, bad_card 0, pending shuffle 0, last-served = dealer (player wins first tie).
REQ-034 reset mid-transaction SHALL abandon it with no grant; deck_ptr returns to 0.

Verification
REQ-035 player_req only, mem_data=7 at slot 0 -> mem_rd at N+1, addr 0; player_grant, card_out=7 at N+3; cards_left=51.
REQ-036 player_req and dealer_req both held from reset -> grants alternate player, dealer, player, dealer at 4-cycle spacing.
REQ-037 slot 2 holds 0, slot 3 holds 5, dealer_req -> bad_card=1, two mem_rd pulses (addr 2, 3), dealer_grant card_out=5 at N+5.
REQ-038 52 valid deals -> deck_empty=1, cards_left=0; further player_req -> no mem_rd, no grant.
REQ-039 shuffle pulse during WAIT -> current card delivered; next IDLE: deck_ptr=0, cards_left=52, deck_empty=0, then held request served from addr 0.
REQ-040 reset low during WAIT -> no grant, all outputs at REQ-033 values within same cycle.

Source files
------------

// File: rtl/card_deal_scheduler.sv
// Card deal scheduler: round-robin arbitration between player and dealer requests,
// one card fetched per grant from an external card memory, invalid slots skipped.
module card_deal_scheduler #(
  parameter int DECK_SIZE = 52,
  parameter int ADDR_W    = 6
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              player_req_i,
  input  logic              dealer_req_i,
  input  logic              shuffle_i,
  input  logic [3:0]        mem_data_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic [3:0]        card_out_o,
  output logic              player_grant_o,
  output logic              dealer_grant_o,
  output logic [ADDR_W-1:0] cards_left_o,
  output logic              deck_empty_o,
  output logic              bad_card_o
);

  localparam logic [ADDR_W-1:0] DECK_FULL = ADDR_W'(DECK_SIZE);
  localparam logic [ADDR_W-1:0] DECK_LAST = ADDR_W'(DECK_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DELIVER
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] deck_ptr_q, deck_ptr_d;
  logic [ADDR_W-1:0] cards_left_q, cards_left_d;
  logic              deck_empty_q, deck_empty_d;
  logic [3:0]        card_q, card_d;
  logic              bad_card_q, bad_card_d;
  logic              shuffle_pend_q, shuffle_pend_d;
  logic              owner_dealer_q, owner_dealer_d;  // 1: current card belongs to dealer
  logic              last_dealer_q, last_dealer_d;    // 1: dealer was served most recently
  logic              card_valid;

  assign card_valid = (mem_data_i != 4'd0) && (mem_data_i <= 4'd13);

  // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d        = state_q;
    deck_ptr_d     = deck_ptr_q;
    cards_left_d   = cards_left_q;
    deck_empty_d   = deck_empty_q;
    card_d         = card_q;
    bad_card_d     = bad_card_q;
    shuffle_pend_d = shuffle_pend_q | shuffle_i;
    owner_dealer_d = owner_dealer_q;
    last_dealer_d  = last_dealer_q;

    unique case (state_q)
      S_IDLE: begin
        // A shuffle (new or deferred) wins over arbitration and starts no fetch this cycle.
        if (shuffle_i || shuffle_pend_q) begin
          deck_ptr_d     = '0;
          cards_left_d   = DECK_FULL;
          deck_empty_d   = 1'b0;
          shuffle_pend_d = 1'b0;
        end else if ((player_req_i || dealer_req_i) && !deck_empty_q) begin
          owner_dealer_d = (player_req_i && dealer_req_i) ? !last_dealer_q : dealer_req_i;
          state_d        = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (!deck_empty_q) begin
          deck_ptr_d   = deck_ptr_q + 1'b1;
          cards_left_d = cards_left_q - 1'b1;
          deck_empty_d = (deck_ptr_q == DECK_LAST);
        end
        if (card_valid) begin
          card_d  = mem_data_i;
          state_d = S_DELIVER;
        end else begin
          bad_card_d = 1'b1;
          state_d    = (deck_ptr_q == DECK_LAST) ? S_IDLE : S_FETCH;
        end
      end
      S_DELIVER: begin
        last_dealer_d = owner_dealer_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= S_IDLE;
      deck_ptr_q     <= '0;
      cards_left_q   <= DECK_FULL;
      deck_empty_q   <= 1'b0;
      card_q         <= '0;
      bad_card_q     <= 1'b0;
      shuffle_pend_q <= 1'b0;
      owner_dealer_q <= 1'b0;
      last_dealer_q  <= 1'b1;
    end else begin
      state_q        <= state_d;
      deck_ptr_q     <= deck_ptr_d;
      cards_left_q   <= cards_left_d;
      deck_empty_q   <= deck_empty_d;
      card_q         <= card_d;
      bad_card_q     <= bad_card_d;
      shuffle_pend_q <= shuffle_pend_d;
      owner_dealer_q <= owner_dealer_d;
      last_dealer_q  <= last_dealer_d;
    end
  end

  assign mem_addr_o     = deck_ptr_q;
  assign mem_rd_o       = (state_q == S_FETCH);
  assign card_out_o     = card_q;
  assign player_grant_o = (state_q == S_DELIVER) && !owner_dealer_q;
  assign dealer_grant_o = (state_q == S_DELIVER) && owner_dealer_q;
  assign cards_left_o   = cards_left_q;
  assign deck_empty_o   = deck_empty_q;
  assign bad_card_o     = bad_card_q;

endmodule

// File: tb/tb_card_deal_scheduler.sv
// Self-checking bench for card_deal_scheduler: randomized deals compared against a
// deck-level reference model (pointer walk over a card array, round-robin by last owner).
module tb_card_deal_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       player_req, dealer_req, shuffle;
  logic [3:0] mem_data = 4'd0;
  logic [5:0] mem_addr;
  logic       mem_rd;
  logic [3:0] card_out;
  logic       player_grant, dealer_grant;
  logic [5:0] cards_left;
  logic       deck_empty, bad_card;

  int checks = 0;
  int errors = 0;

  logic [3:0] deck_mem [64];
  int         m_ptr;
  bit         m_last_dealer;
  bit         m_bad;

  card_deal_scheduler #(.DECK_SIZE(52), .ADDR_W(6)) dut (
    .clock_i        (clk),
    .reset_ni       (rst_n),
    .player_req_i   (player_req),
    .dealer_req_i   (dealer_req),
    .shuffle_i      (shuffle),
    .mem_data_i     (mem_data),
    .mem_addr_o     (mem_addr),
    .mem_rd_o       (mem_rd),
    .card_out_o     (card_out),
    .player_grant_o (player_grant),
    .dealer_grant_o (dealer_grant),
    .cards_left_o   (cards_left),
    .deck_empty_o   (deck_empty),
    .bad_card_o     (bad_card)
  );

  always #5 clk = ~clk;

  // Card memory: data for a read strobe appears one cycle later.
  always @(posedge clk) if (mem_rd) mem_data <= deck_mem[mem_addr];

  task automatic fill_deck(input int bad_pct);
    for (int i = 0; i < 64; i++) begin
      if (int'($urandom_range(99)) < bad_pct) begin
        int v = int'($urandom_range(2));
        deck_mem[i] = (v == 0) ? 4'd0 : 4'(13 + v);
      end else begin
        deck_mem[i] = 4'($urandom_range(13, 1));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; player_req = 1'b0; dealer_req = 1'b0; shuffle = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_last_dealer = 1'b1; m_bad = 1'b0;
  endtask

  task automatic pick_reqs(output logic p, output logic d);
    int r = int'($urandom_range(2));
    p = (r != 1);
    d = (r != 0);
  endtask

  // One request episode from IDLE, called at a negedge; model walks the deck to predict it.
  task automatic run_deal(input logic p, input logic d);
    int exp_addrs[$];
    int got_addrs[$];
    int ptr = m_ptr;
    int nbad = 0;
    bit exp_grant = 1'b0;
    bit exp_dealer;
    logic [3:0] exp_card = 4'd0;
    int exp_lat, window;
    int got_i = -1, first_rd = -1, ngrant = 0;
    bit both = 1'b0, got_dealer = 1'b0;
    logic [3:0] got_card = 4'd0;

    exp_dealer = (p && d) ? !m_last_dealer : d;
    while (ptr < 52 && !exp_grant) begin
      exp_addrs.push_back(ptr);
      ptr++;
      if (deck_mem[ptr-1] inside {[4'd1:4'd13]}) begin
        exp_grant = 1'b1;
        exp_card  = deck_mem[ptr-1];
      end else begin
        m_bad = 1'b1;
        nbad++;
      end
    end
    exp_lat = 3 + 2 * nbad;
    window  = exp_lat + 2;

    player_req = p; dealer_req = d;
    for (int i = 1; i <= window; i++) begin
      @(negedge clk);
      if (mem_rd) begin
        got_addrs.push_back(int'(mem_addr));
        if (first_rd < 0) first_rd = i;
      end
      if (player_grant && dealer_grant) both = 1'b1;
      if (player_grant || dealer_grant) begin
        ngrant++; got_i = i; got_dealer = dealer_grant; got_card = card_out;
        player_req = 1'b0; dealer_req = 1'b0;
      end
    end
    player_req = 1'b0; dealer_req = 1'b0;

    checks++;
    if (both) begin errors++; $display("FAIL deal_both_grants: both grants high together"); end
    checks++;
    if (ngrant != int'(exp_grant)) begin
      errors++; $display("FAIL deal_grant_count: got %0d, want %0d (ptr %0d)", ngrant, exp_grant, m_ptr);
    end else if (exp_grant) begin
      checks++;
      if (got_i != exp_lat || got_dealer != exp_dealer || got_card !== exp_card) begin
        errors++;
        $display("FAIL deal_grant: got lat=%0d dealer=%0b card=%0d, want lat=%0d dealer=%0b card=%0d",
                 got_i, got_dealer, got_card, exp_lat, exp_dealer, exp_card);
      end
    end
    checks++;
    if (got_addrs.size() != exp_addrs.size()) begin
      errors++; $display("FAIL deal_rd_count: got %0d reads, want %0d", got_addrs.size(), exp_addrs.size());
    end else begin
      foreach (exp_addrs[k]) begin
        checks++;
        if (got_addrs[k] != exp_addrs[k]) begin
          errors++; $display("FAIL deal_rd_addr%0d: got %0d, want %0d", k, got_addrs[k], exp_addrs[k]);
        end
      end
      if (exp_addrs.size() > 0) begin
        checks++;
        if (first_rd != 1) begin errors++; $display("FAIL deal_rd_latency: got %0d, want 1", first_rd); end
      end
    end
    checks++;
    if (int'(cards_left) != 52 - ptr || deck_empty !== (ptr == 52) || bad_card !== m_bad) begin
      errors++;
      $display("FAIL deal_status: got left=%0d empty=%0b bad=%0b, want left=%0d empty=%0b bad=%0b",
               cards_left, deck_empty, bad_card, 52 - ptr, (ptr == 52), m_bad);
    end
    m_ptr = ptr;
    if (exp_grant) m_last_dealer = exp_dealer;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (mem_rd !== 1'b0 || mem_addr !== 6'd0 || card_out !== 4'd0 || player_grant !== 1'b0 ||
        dealer_grant !== 1'b0 || cards_left !== 6'd52 || deck_empty !== 1'b0 || bad_card !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rd=%0b addr=%0d card=%0d pg=%0b dg=%0b left=%0d empty=%0b bad=%0b, want 0 0 0 0 0 52 0 0",
               tag, mem_rd, mem_addr, card_out, player_grant, dealer_grant, cards_left, deck_empty, bad_card);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset_state");
  endtask

  task automatic test_single_player();
    fill_deck(0);
    deck_mem[0] = 4'd7;
    run_deal(1'b1, 1'b0);
    checks++;
    if (card_out !== 4'd7 || cards_left !== 6'd51) begin
      errors++; $display("FAIL single_player: got card=%0d left=%0d, want card=7 left=51", card_out, cards_left);
    end
  endtask

  task automatic test_round_robin();
    int g_t[$]; bit g_d[$]; logic [3:0] g_c[$];
    fill_deck(0);
    rst_n = 1'b0; player_req = 1'b1; dealer_req = 1'b1; shuffle = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (player_grant || dealer_grant) begin
        g_t.push_back(i); g_d.push_back(dealer_grant); g_c.push_back(card_out);
      end
    end
    player_req = 1'b0; dealer_req = 1'b0;
    checks++;
    if (g_t.size() != 4) begin
      errors++; $display("FAIL rr_count: got %0d grants, want 4", g_t.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (g_t[k] != 3 + 4 * k || g_d[k] != k[0] || g_c[k] !== deck_mem[k]) begin
          errors++;
          $display("FAIL rr_grant%0d: got t=%0d dealer=%0b card=%0d, want t=%0d dealer=%0b card=%0d",
                   k, g_t[k], g_d[k], g_c[k], 3 + 4 * k, k[0], deck_mem[k]);
        end
      end
    end
    m_ptr = 4; m_last_dealer = 1'b1; m_bad = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bad_card();
    logic p, d;
    do_reset();
    fill_deck(0);
    deck_mem[2] = 4'd0;
    deck_mem[3] = 4'd5;
    for (int i = 0; i < 2; i++) begin
      pick_reqs(p, d);
      run_deal(p, d);
    end
    run_deal(1'b0, 1'b1);
  endtask

  task automatic test_full_deck();
    logic p, d;
    do_reset();
    fill_deck(0);
    for (int i = 0; i < 52; i++) begin
      pick_reqs(p, d);
      run_deal(p, d);
    end
    checks++;
    if (deck_empty !== 1'b1 || cards_left !== 6'd0) begin
      errors++; $display("FAIL full_deck: got empty=%0b left=%0d, want 1 0", deck_empty, cards_left);
    end
    run_deal(1'b1, 1'b0);
  endtask

  task automatic test_random_bad();
    logic p, d;
    do_reset();
    fill_deck(20);
    deck_mem[5] = 4'd15;
    for (int i = 0; i < 60 && m_ptr < 52; i++) begin
      pick_reqs(p, d);
      run_deal(p, d);
    end
  endtask

  task automatic test_shuffle_idle();
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    checks++;
    if (cards_left !== 6'd52 || deck_empty !== 1'b0 || mem_addr !== 6'd0 || bad_card !== m_bad) begin
      errors++;
      $display("FAIL shuffle_idle: got left=%0d empty=%0b addr=%0d bad=%0b, want 52 0 0 %0b",
               cards_left, deck_empty, mem_addr, bad_card, m_bad);
    end
    m_ptr = 0;
    deck_mem[0] = 4'd9;
    run_deal(1'b1, 1'b0);
    shuffle = 1'b1; player_req = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    checks++;
    if (mem_rd !== 1'b0 || cards_left !== 6'd52) begin
      errors++; $display("FAIL shuffle_priority: got rd=%0b left=%0d, want 0 52", mem_rd, cards_left);
    end
    m_ptr = 0;
    run_deal(1'b1, 1'b0);
  endtask

  task automatic test_shuffle_wait();
    int g_t[$]; logic [3:0] g_c[$]; int rd_t[$]; int rd_a[$];
    int left5 = -1, addr5 = -1;
    logic empty5 = 1'bx;
    logic [3:0] first_card;
    deck_mem[m_ptr] = 4'($urandom_range(13, 1));
    deck_mem[0]     = 4'($urandom_range(13, 1));
    first_card      = deck_mem[m_ptr];
    player_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      shuffle = (i == 2);
      if (mem_rd) begin rd_t.push_back(i); rd_a.push_back(int'(mem_addr)); end
      if (player_grant) begin g_t.push_back(i); g_c.push_back(card_out); end
      if (i == 5) begin left5 = int'(cards_left); addr5 = int'(mem_addr); empty5 = deck_empty; end
    end
    player_req = 1'b0;
    shuffle    = 1'b0;
    checks++;
    if (g_t.size() != 2) begin
      errors++; $display("FAIL shuffle_wait_grants: got %0d, want 2", g_t.size());
    end else begin
      checks++;
      if (g_t[0] != 3 || g_c[0] !== first_card || g_t[1] != 8 || g_c[1] !== deck_mem[0]) begin
        errors++;
        $display("FAIL shuffle_wait_cards: got t=%0d/%0d card=%0d/%0d, want t=3/8 card=%0d/%0d",
                 g_t[0], g_t[1], g_c[0], g_c[1], first_card, deck_mem[0]);
      end
    end
    checks++;
    if (left5 != 52 || addr5 != 0 || empty5 !== 1'b0) begin
      errors++; $display("FAIL shuffle_wait_restart: got left=%0d addr=%0d empty=%0b, want 52 0 0", left5, addr5, empty5);
    end
    checks++;
    if (rd_t.size() != 2 || rd_t[1] != 6 || rd_a[1] != 0) begin
      errors++; $display("FAIL shuffle_wait_reads: got %0d reads, want 2 with second at t=6 addr 0", rd_t.size());
    end
    checks++;
    if (bad_card !== m_bad) begin
      errors++; $display("FAIL bad_card_sticky: got %0b, want %0b", bad_card, m_bad);
    end
    m_ptr = 1; m_last_dealer = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ngrant = 0;
    dealer_req = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_wait");
    dealer_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_last_dealer = 1'b1; m_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (player_grant || dealer_grant || mem_rd) ngrant++;
    end
    checks++;
    if (ngrant != 0) begin errors++; $display("FAIL reset_mid_after: got %0d active cycles, want 0", ngrant); end
    check_reset_outputs("reset_mid_idle");
  endtask

  initial begin
    rst_n = 1'b0; player_req = 1'b0; dealer_req = 1'b0; shuffle = 1'b0;
    test_reset();
    test_single_player();
    test_round_robin();
    test_bad_card();
    test_full_deck();
    test_random_bad();
    test_shuffle_idle();
    test_shuffle_wait();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
